// File: rtl/pipe_stage_reg_if.sv
// Handshake bundles for a pipeline boundary register.
// The upstream side carries the raw word. The downstream side also carries
// the precomputed PC+4 and PC+8.

interface pipe_stage_reg_in_if #(
  parameter int DATA_W = 32,
  parameter int EXC_W  = 5
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] instr;
  logic [31:0]       pc;
  logic [EXC_W-1:0]  exc;
  logic              bd;

  modport master (output valid, instr, pc, exc, bd, input  ready);
  modport slave  (input  valid, instr, pc, exc, bd, output ready);
endinterface

interface pipe_stage_reg_out_if #(
  parameter int DATA_W = 32,
  parameter int EXC_W  = 5
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] instr;
  logic [31:0]       pc;
  logic [31:0]       pc4;
  logic [31:0]       pc8;
  logic [EXC_W-1:0]  exc;
  logic              bd;

  modport master (output valid, instr, pc, pc4, pc8, exc, bd, input  ready);
  modport slave  (input  valid, instr, pc, pc4, pc8, exc, bd, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// Elastic stage-boundary register with a one-entry skid buffer.
// The main entry drives the outputs. The skid entry absorbs one word while
// downstream is blocked. Because of the skid entry, in_ready depends only on
// registered state.

module pipe_stage_reg #(
  parameter int          DATA_W      = 32,
  parameter logic [31:0] PC_RESET    = 32'h0000_3000,
  parameter int          EXC_W       = 5,
  parameter int unsigned ADEL_CODE   = 4,
  parameter bit          CHECK_ALIGN = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,   // asynchronous, active-low
  input  logic                  stall,
  input  logic                  flush,
  pipe_stage_reg_in_if.slave    up,
  pipe_stage_reg_out_if.master  dn
);

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [31:0]       pc;
    logic [31:0]       pc4;
    logic [31:0]       pc8;
    logic [EXC_W-1:0]  exc;
    logic              bd;
  } word_t;

  typedef enum logic [1:0] {S_EMPTY, S_FULL, S_SKID} state_t;

  localparam word_t RST_WORD = '{
    instr: '0,
    pc:    PC_RESET,
    pc4:   PC_RESET + 32'd4,
    pc8:   PC_RESET + 32'd8,
    exc:   '0,
    bd:    1'b0
  };

  state_t state, state_nx;
  word_t  main_q, skid_q, in_word;
  logic   accept, consume;
  logic   ld_main_in, ld_main_skid, ld_skid;

  // Readiness and validity come straight from the state flops.
  assign up.ready = (state != S_SKID);
  assign dn.valid = (state != S_EMPTY);

  assign accept  = up.valid & up.ready;
  assign consume = dn.valid & dn.ready & ~stall;

  // Shape the incoming word: PC+4/PC+8 with natural 32-bit wrap, and tag a
  // misaligned fetch with an address error unless upstream already faulted.
  always_comb begin
    in_word.instr = up.instr;
    in_word.pc    = up.pc;
    in_word.pc4   = up.pc + 32'd4;
    in_word.pc8   = up.pc + 32'd8;
    in_word.exc   = up.exc;
    in_word.bd    = up.bd;
    if (CHECK_ALIGN && (up.pc[1:0] != 2'b00) && (up.exc == '0)) begin
      in_word.exc   = EXC_W'(ADEL_CODE);
      in_word.instr = '0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_EMPTY;
    else        state <= state_nx;
  end

  // Next state and entry-load strobes. Flush overrides every other event.
  always_comb begin
    state_nx     = state;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    if (flush) begin
      state_nx = S_EMPTY;
    end else begin
      unique case (state)
        S_EMPTY: begin
          if (accept) begin
            ld_main_in = 1'b1;
            state_nx   = S_FULL;
          end
        end
        S_FULL: begin
          if (accept && consume) begin
            ld_main_in = 1'b1;
          end else if (accept) begin
            ld_skid  = 1'b1;
            state_nx = S_SKID;
          end else if (consume) begin
            state_nx = S_EMPTY;
          end
        end
        S_SKID: begin
          if (consume) begin
            ld_main_skid = 1'b1;
            state_nx     = S_FULL;
          end
        end
        default: state_nx = S_EMPTY;
      endcase
    end
  end

  // Main entry. A flush wipes the payload but keeps the PC fields, so the
  // outputs still show where the pipe last was.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_q <= RST_WORD;
    end else if (flush) begin
      main_q.instr <= '0;
      main_q.exc   <= '0;
      main_q.bd    <= 1'b0;
    end else if (ld_main_in) begin
      main_q <= in_word;
    end else if (ld_main_skid) begin
      main_q <= skid_q;
    end
  end

  // Skid entry. Its contents only matter while the state is S_SKID.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       skid_q <= '0;
    else if (ld_skid) skid_q <= in_word;
  end

  // A bubble reads as a zero instruction with no exception. The PC fields
  // always show the main entry.
  assign dn.instr = dn.valid ? main_q.instr : '0;
  assign dn.exc   = dn.valid ? main_q.exc   : '0;
  assign dn.bd    = dn.valid ? main_q.bd    : 1'b0;
  assign dn.pc    = main_q.pc;
  assign dn.pc4   = main_q.pc4;
  assign dn.pc8   = main_q.pc8;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg. A FIFO-level model (queue of at most two words)
// is checked on every falling edge. Directed steps add literal expectations.
// A second instance with CHECK_ALIGN=0 covers pass-through of misaligned words.

module tb_pipe_stage_reg;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic stall = 1'b0;
  logic flush = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  pipe_stage_reg_in_if  u_in ();
  pipe_stage_reg_out_if u_out ();
  pipe_stage_reg_in_if  n_in ();
  pipe_stage_reg_out_if n_out ();

  pipe_stage_reg dut (
    .clk(clk), .reset(rst_n), .stall(stall), .flush(flush),
    .up(u_in.slave), .dn(u_out.master)
  );

  pipe_stage_reg #(.CHECK_ALIGN(1'b0)) dut_na (
    .clk(clk), .reset(rst_n), .stall(1'b0), .flush(1'b0),
    .up(n_in.slave), .dn(n_out.master)
  );

  // The pass-through instance sees the same input stream and never backs up.
  assign n_in.valid  = u_in.valid;
  assign n_in.instr  = u_in.instr;
  assign n_in.pc     = u_in.pc;
  assign n_in.exc    = u_in.exc;
  assign n_in.bd     = u_in.bd;
  assign n_out.ready = 1'b1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  exc;
    logic        bd;
  } mw_t;

  mw_t         mq[$];
  logic [31:0] m_pc = 32'h0000_3000;

  function automatic mw_t mk(input logic [31:0] instr, input logic [31:0] pc,
                             input logic [4:0] exc, input logic bd);
    mw_t w;
    w.instr = instr; w.pc = pc; w.exc = exc; w.bd = bd;
    if (pc[1:0] != 2'b00 && exc == 5'd0) begin
      w.exc   = 5'd4;
      w.instr = 32'd0;
    end
    return w;
  endfunction

  // Inputs are stable from 2 time units after a rising edge until the next
  // rising edge. On each falling edge, compare the outputs of the last
  // rising edge, then advance the model for the next rising edge.
  always @(negedge clk) begin
    logic        acc, con, mv;
    logic [31:0] e_pc;
    if (!rst_n) begin
      mq.delete();
      m_pc = 32'h0000_3000;
    end
    mv   = (mq.size() > 0);
    e_pc = mv ? mq[0].pc : m_pc;
    chk("m_out_valid", {63'd0, u_out.valid}, {63'd0, mv});
    chk("m_in_ready",  {63'd0, u_in.ready},  {63'd0, (mq.size() < 2)});
    chk("m_out_pc",    {32'd0, u_out.pc},    {32'd0, e_pc});
    chk("m_out_pc4",   {32'd0, u_out.pc4},   {32'd0, e_pc + 32'd4});
    chk("m_out_pc8",   {32'd0, u_out.pc8},   {32'd0, e_pc + 32'd8});
    chk("m_out_instr", {32'd0, u_out.instr}, {32'd0, (mv ? mq[0].instr : 32'd0)});
    chk("m_out_exc",   {59'd0, u_out.exc},   {59'd0, (mv ? mq[0].exc : 5'd0)});
    if (mv) chk("m_out_bd", {63'd0, u_out.bd}, {63'd0, mq[0].bd});
    if (rst_n) begin
      acc = u_in.valid && (mq.size() < 2);
      con = (mq.size() > 0) && u_out.ready && !stall;
      if (flush) begin
        mq.delete();
      end else begin
        if (con) void'(mq.pop_front());
        if (acc) mq.push_back(mk(u_in.instr, u_in.pc, u_in.exc, u_in.bd));
      end
      if (mq.size() > 0) m_pc = mq[0].pc;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic [4:0] exc, input logic bd);
    u_in.valid = v; u_in.instr = instr; u_in.pc = pc; u_in.exc = exc; u_in.bd = bd;
  endtask

  initial begin
    drive(1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
    u_out.ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", {63'd0, u_out.valid}, 64'd0);
    chk("rst_ready", {63'd0, u_in.ready},  64'd1);
    chk("rst_pc",    {32'd0, u_out.pc},    64'h3000);
    chk("rst_pc8",   {32'd0, u_out.pc8},   64'h3008);
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
    chk("rel_valid", {63'd0, u_out.valid}, 64'd0);
    chk("rel_pc4",   {32'd0, u_out.pc4},   64'h3004);
    chk("rel_instr", {32'd0, u_out.instr}, 64'd0);

    // Streaming at full rate.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h2408_0001 + 32'(i), 32'h3000 + 32'(4 * i), 5'd0, 1'b0);
      cyc();
      chk("str_instr", {32'd0, u_out.instr}, {32'd0, 32'h2408_0001 + 32'(i)});
      chk("str_pc4",   {32'd0, u_out.pc4},   {32'd0, 32'h3004 + 32'(4 * i)});
      chk("str_ready", {63'd0, u_in.ready},  64'd1);
    end
    drive(1'b0, 32'd0, 32'h3100, 5'd0, 1'b0);
    cyc();

    // Backpressure: A to main, B to skid, C refused.
    u_out.ready = 1'b0;
    drive(1'b1, 32'h1111_0000, 32'h3100, 5'd0, 1'b0);
    cyc();
    drive(1'b1, 32'h2222_0000, 32'h3104, 5'd0, 1'b1);
    cyc();
    chk("bp_ready0", {63'd0, u_in.ready},  64'd0);
    chk("bp_headA",  {32'd0, u_out.instr}, 64'h1111_0000);
    drive(1'b1, 32'h3333_0000, 32'h3108, 5'd0, 1'b0);
    cyc();
    drive(1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
    u_out.ready = 1'b1;
    cyc();
    chk("bp_headB",  {32'd0, u_out.instr}, 64'h2222_0000);
    chk("bp_bdB",    {63'd0, u_out.bd},    64'd1);
    chk("bp_ready1", {63'd0, u_in.ready},  64'd1);
    cyc();
    chk("bp_drained", {63'd0, u_out.valid}, 64'd0);

    // Stall holds D, then flush drops E while D is consumed.
    drive(1'b1, 32'h4444_0000, 32'h3180, 5'd0, 1'b0);
    cyc();
    drive(1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_hold", {32'd0, u_out.instr}, 64'h4444_0000);
    end
    stall = 1'b0;
    flush = 1'b1;
    drive(1'b1, 32'h5555_0000, 32'h3200, 5'd0, 1'b0);
    cyc();
    flush = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
    chk("fl_valid", {63'd0, u_out.valid}, 64'd0);
    chk("fl_instr", {32'd0, u_out.instr}, 64'd0);
    chk("fl_pc",    {32'd0, u_out.pc},    64'h3180);
    cyc();
    chk("fl_noE",   {63'd0, u_out.valid}, 64'd0);

    // Misaligned PC.
    drive(1'b1, 32'h2408_00FF, 32'h3002, 5'd0, 1'b0);
    cyc();
    chk("mis_exc",    {59'd0, u_out.exc},   64'd4);
    chk("mis_instr",  {32'd0, u_out.instr}, 64'd0);
    chk("na_exc",     {59'd0, n_out.exc},   64'd0);
    chk("na_instr",   {32'd0, n_out.instr}, 64'h2408_00FF);
    drive(1'b1, 32'h2408_00EE, 32'h3002, 5'd6, 1'b0);
    cyc();
    chk("mis_exc6",   {59'd0, u_out.exc},   64'd6);
    chk("na_exc6",    {59'd0, n_out.exc},   64'd6);

    // PC wrap.
    drive(1'b1, 32'h0000_0001, 32'hFFFF_FFFC, 5'd0, 1'b0);
    cyc();
    chk("wrap_pc4", {32'd0, u_out.pc4}, 64'h0);
    chk("wrap_pc8", {32'd0, u_out.pc8}, 64'h4);
    drive(1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
    cyc();

    // Mixed traffic table, model-checked every cycle.
    for (int i = 0; i < 24; i++) begin
      drive((i % 3) != 2, 32'hA000_0000 + 32'(i), 32'h4000 + 32'(4 * i), 5'd0, i[0]);
      u_out.ready = (i % 4) < 2;
      stall = (i == 9);
      flush = (i == 17);
      cyc();
    end
    stall = 1'b0;
    flush = 1'b0;
    u_out.ready = 1'b0;

    // Reset in mid-stream clears outputs without a clock edge.
    drive(1'b1, 32'h7777_0000, 32'h5000, 5'd0, 1'b0);
    cyc();
    cyc();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {63'd0, u_out.valid}, 64'd0);
    chk("mid_rst_ready", {63'd0, u_in.ready},  64'd1);
    chk("mid_rst_pc",    {32'd0, u_out.pc},    64'h3000);
    drive(1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
    u_out.ready = 1'b1;
    cyc();
    rst_n = 1'b1;
    repeat (3) cyc();
    chk("post_rst_valid", {63'd0, u_out.valid}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected finish before 100000");
    $fatal(1);
  end

endmodule
